// File: rtl/ddr_judge_ctrl_pkg.sv
// Shared types and constants for the DDR judge controller slice.
package ddr_pkg;

  localparam int LANE_W      = 4;
  localparam int COMBO_W     = 8;
  localparam int PTS_PERFECT = 3;
  localparam int PTS_GOOD    = 1;

  typedef enum logic [1:0] {
    J_NONE    = 2'd0,
    J_PERFECT = 2'd1,
    J_GOOD    = 2'd2,
    J_MISS    = 2'd3
  } judge_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_TRAVEL,
    S_WINDOW,
    S_JUDGE,
    S_ADVANCE,
    S_WAIT,
    S_DONE
  } state_e;

  function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/ddr_judge_ctrl_if.sv
// Chart, button and renderer signals of the judge controller.
interface ddr_judge_if #(
  parameter int SCORE_W = 16
) ();
  import ddr_pkg::*;

  logic               frame_i;
  logic               start_i;
  logic [LANE_W-1:0]  btn_i;
  logic [LANE_W-1:0]  arrows_i;
  logic [3:0]         timing_i;
  logic               next_o;
  logic [7:0]         target_o;
  logic               judge_valid_o;
  judge_e             judge_o;
  logic [SCORE_W-1:0] score_o;
  logic [COMBO_W-1:0] combo_o;
  logic               playing_o;
  logic               done_o;

  modport slave (
    input  frame_i, start_i, btn_i, arrows_i, timing_i,
    output next_o, target_o, judge_valid_o, judge_o, score_o, combo_o, playing_o, done_o
  );

  modport master (
    output frame_i, start_i, btn_i, arrows_i, timing_i,
    input  next_o, target_o, judge_valid_o, judge_o, score_o, combo_o, playing_o, done_o
  );

endinterface

// File: rtl/ddr_judge_ctrl_frame_timer.sv
// Frame counter for one chart step: counts frames since load and flags
// the opening and the expiry of the hit window around the target t.
module ddr_frame_timer #(
  parameter int GOOD_WIN = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       run,
  input  logic       frame,
  input  logic [7:0] t,
  output logic [7:0] cnt,
  output logic       in_window,
  output logic       expired
);

  logic [8:0] cnt_inc;
  logic [8:0] win_lo;
  logic [8:0] win_hi;

  // Nine-bit compares so t + GOOD_WIN cannot wrap for large gap codes.
  assign cnt_inc   = {1'b0, cnt} + 9'd1;
  assign win_lo    = {1'b0, t} - 9'(GOOD_WIN);
  assign win_hi    = {1'b0, t} + 9'(GOOD_WIN);
  assign in_window = frame && run && (cnt_inc >= win_lo);
  assign expired   = frame && run && ({1'b0, cnt} == win_hi);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (run && frame) begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/ddr_judge_ctrl.sv
// Judging sequencer: loads chart steps, grades presses, keeps score/combo.
// Define DDR_AUTOPLAY_EN for attract mode (a perfect press on every note).
module ddr_judge_ctrl
  import ddr_pkg::*;
#(
  parameter int TRAVEL_FRAMES = 60,
  parameter int GAP_SHIFT     = 3,
  parameter int GOOD_WIN      = 6,
  parameter int PERFECT_WIN   = 2,
  parameter int SCORE_W       = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  ddr_judge_if.slave bus
);

  state_e             state;
  judge_e             grade;
  judge_e             judge;
  logic [7:0]         t_q;
  logic [7:0]         t_load;
  logic [7:0]         cnt;
  logic [7:0]         err;
  logic [LANE_W-1:0]  pressed;
  logic [LANE_W-1:0]  press;
  logic [LANE_W-1:0]  hit;
  logic [LANE_W-1:0]  stray;
  logic [LANE_W-1:0]  pressed_all;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W:0]   pts;
  logic [COMBO_W-1:0] combo;
  logic [COMBO_W-1:0] combo_inc;
  logic               in_window;
  logic               expired;
  logic               rest;
  logic               end_marker;
  logic               judge_valid;
  logic               next;
  logic               playing;
  logic               done;

  ddr_frame_timer #(.GOOD_WIN(GOOD_WIN)) u_timer (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .load      (state == S_LOAD),
    .run       ((state == S_TRAVEL) || (state == S_WINDOW)),
    .frame     (bus.frame_i),
    .t         (t_q),
    .cnt       (cnt),
    .in_window (in_window),
    .expired   (expired)
  );

`ifdef DDR_AUTOPLAY_EN
  assign press = ((state == S_WINDOW) && (cnt == t_q)) ? bus.arrows_i : '0;
`else
  assign press = bus.btn_i;
`endif

  assign t_load      = 8'(TRAVEL_FRAMES + (int'(bus.timing_i) << GAP_SHIFT));
  assign rest        = (bus.arrows_i == '0);
  assign end_marker  = rest && (bus.timing_i == '0);
  assign hit         = press & bus.arrows_i;
  assign stray       = press & ~bus.arrows_i;
  assign pressed_all = pressed | hit;
  assign err         = abs_diff(cnt, t_q);

  always_comb begin
    pts = '0;
    if (grade == J_PERFECT) pts = (SCORE_W+1)'(PTS_PERFECT);
    else if (grade == J_GOOD) pts = (SCORE_W+1)'(PTS_GOOD);
    score_sum = {1'b0, score} + pts;
    combo_inc = (combo == '1) ? combo : combo + COMBO_W'(1);
  end

  // Outputs are registered alongside the state, so they trail it by a cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= S_IDLE;
      grade       <= J_NONE;
      judge       <= J_NONE;
      t_q         <= '0;
      pressed     <= '0;
      score       <= '0;
      combo       <= '0;
      judge_valid <= 1'b0;
      next        <= 1'b0;
      playing     <= 1'b0;
      done        <= 1'b0;
    end else begin
      judge_valid <= 1'b0;
      judge       <= J_NONE;
      next        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start_i) begin
            state   <= S_LOAD;
            playing <= 1'b1;
          end
        end
        S_LOAD: begin
          if (end_marker) begin
            state   <= S_DONE;
            playing <= 1'b0;
            done    <= 1'b1;
          end else begin
            t_q     <= t_load;
            pressed <= '0;
            state   <= (t_load < 8'(GOOD_WIN)) ? S_WINDOW : S_TRAVEL;
          end
        end
        S_TRAVEL: begin
          if (in_window) state <= S_WINDOW;
        end
        S_WINDOW: begin
          // A completing or wrong press outranks expiry on the same frame.
          if (rest) begin
            if (cnt >= t_q) state <= S_ADVANCE;
          end else if (stray != '0) begin
            grade <= J_MISS;
            state <= S_JUDGE;
          end else if (pressed_all == bus.arrows_i) begin
            grade <= (err <= 8'(PERFECT_WIN)) ? J_PERFECT : J_GOOD;
            state <= S_JUDGE;
          end else if (expired) begin
            grade <= J_MISS;
            state <= S_JUDGE;
          end else begin
            pressed <= pressed_all;
          end
        end
        S_JUDGE: begin
          judge_valid <= 1'b1;
          judge       <= grade;
          score       <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
          combo       <= (grade == J_MISS) ? '0 : combo_inc;
          state       <= S_ADVANCE;
        end
        S_ADVANCE: begin
          next  <= 1'b1;
          state <= S_WAIT;
        end
        S_WAIT: begin
          state <= S_LOAD;
        end
        S_DONE: begin
          if (bus.start_i) begin
            score   <= '0;
            combo   <= '0;
            done    <= 1'b0;
            playing <= 1'b1;
            state   <= S_LOAD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.target_o      = (t_q > cnt) ? (t_q - cnt) : 8'd0;
  assign bus.next_o        = next;
  assign bus.judge_valid_o = judge_valid;
  assign bus.judge_o       = judge;
  assign bus.score_o       = score;
  assign bus.combo_o       = combo;
  assign bus.playing_o     = playing;
  assign bus.done_o        = done;

endmodule
